// File: rtl/uartio2.sv
// uartio2: bus-mapped 8N1 UART with RX/TX FIFOs, runtime baud divisor, sticky error flags and level irq.
// Optional internal loopback (CONTROL b4) is built when UARTIO2_LOOPBACK_EN is defined.

module uartio2_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               head_c,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic          pop_ok, push_ok;

  // A push into a full FIFO still lands when a pop frees a slot in the same cycle.
  assign pop_ok  = pop && (cnt != '0);
  assign push_ok = push && !flush && ((cnt != CW'(DEPTH)) || pop_ok);
  assign head_c  = mem[rp];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + PW'(1);
      if (pop_ok)  rp <= rp + PW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end
endmodule

module uartio2 #(
  parameter int unsigned CLK_HZ     = 3000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       rxd,
  output logic       txd
);
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          acc_wr, acc_rd;
  logic          wr_data, wr_stat, wr_ctrl, wr_divlo, wr_divhi, rd_data;
  logic          rx_flush, tx_flush;
  logic          rxie, txie, ovr, fe, loop_rd;
  logic [15:0]   div;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [7:0]    rx_head, tx_head;
  logic          rx_ne, tx_nf, tx_done;

  state_t        tx_state, tx_state_n;
  logic [15:0]   tx_tmr, tx_tmr_n, tx_div, tx_div_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          tx_load_c, tx_avail, tx_line_n, txd_n;

  state_t        rx_state, rx_state_n;
  logic [15:0]   rx_tmr, rx_tmr_n, rx_div, rx_div_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic          rx_push_c, rx_fe_c, rx_drop_c;
  logic          rx_in, rx_s1, rx_s2, rx_s3;
  logic [16:0]   rx_half;

  // Bus decode: every side effect is qualified by cs.
  assign acc_wr   = cs && !rw;
  assign acc_rd   = cs && rw;
  assign wr_data  = acc_wr && (AD == 3'd0);
  assign wr_stat  = acc_wr && (AD == 3'd1);
  assign wr_ctrl  = acc_wr && (AD == 3'd2);
  assign wr_divlo = acc_wr && (AD == 3'd3);
  assign wr_divhi = acc_wr && (AD == 3'd4);
  assign rd_data  = acc_rd && (AD == 3'd0);
  assign rx_flush = wr_ctrl && DI[2];
  assign tx_flush = wr_ctrl && DI[3];

  assign rx_ne   = (rx_cnt != '0);
  assign tx_nf   = (tx_cnt != CW'(FIFO_DEPTH));
  assign tx_done = (tx_cnt == '0) && (tx_state == S_IDLE);

  uartio2_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .flush(rx_flush), .push(rx_push_c), .pop(rd_data),
    .din(rx_sh), .head_c(rx_head), .cnt(rx_cnt)
  );

  uartio2_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .flush(tx_flush), .push(wr_data), .pop(tx_load_c),
    .din(DI), .head_c(tx_head), .cnt(tx_cnt)
  );

  assign rx_drop_c = rx_push_c && !rx_flush && !tx_nf_rx_dummy_free();

  function automatic logic tx_nf_rx_dummy_free();
    return (rx_cnt != CW'(FIFO_DEPTH)) || (rd_data && rx_ne);
  endfunction

`ifdef UARTIO2_LOOPBACK_EN
  logic loop, tx_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      loop    <= 1'b0;
      tx_line <= 1'b1;
    end else begin
      if (wr_ctrl) loop <= DI[4];
      tx_line <= tx_line_n;
    end
  end

  assign rx_in   = loop ? tx_line : rxd;
  assign txd_n   = loop ? 1'b1 : tx_line_n;
  assign loop_rd = loop;
`else
  assign rx_in   = rxd;
  assign txd_n   = tx_line_n;
  assign loop_rd = 1'b0;
`endif

  // Control, divisor, sticky flags and the registered interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxie <= 1'b0;
      txie <= 1'b0;
      div  <= DIV_RESET;
      ovr  <= 1'b0;
      fe   <= 1'b0;
      irq  <= 1'b0;
      txd  <= 1'b1;
    end else begin
      if (wr_ctrl) begin
        rxie <= DI[0];
        txie <= DI[1];
      end
      if (wr_divlo) div[7:0]  <= DI;
      if (wr_divhi) div[15:8] <= DI;
      ovr <= (ovr && !(wr_stat && DI[3])) || rx_drop_c;
      fe  <= (fe  && !(wr_stat && DI[4])) || rx_fe_c;
      irq <= (rxie && rx_ne) || (txie && (tx_cnt == '0));
      txd <= txd_n;
    end
  end

  always_comb begin
    DO = '0;
    case (AD)
      3'd0:    DO = rx_ne ? rx_head : 8'h00;
      3'd1:    DO = {irq, 2'b00, fe, ovr, tx_done, tx_nf, rx_ne};
      3'd2:    DO = {3'b000, loop_rd, 2'b00, txie, rxie};
      3'd3:    DO = div[7:0];
      3'd4:    DO = div[15:8];
      3'd5:    DO = 8'(rx_cnt);
      3'd6:    DO = 8'(tx_cnt);
      default: DO = 8'h00;
    endcase
  end

  // TX shifter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_tmr   <= '0;
      tx_div   <= DIV_RESET;
      tx_bit   <= '0;
      tx_sh    <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_tmr   <= tx_tmr_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
    end
  end

  assign tx_avail = (tx_cnt != '0) && !tx_flush;

  // TX next state; STOP chains straight into the next START when data is waiting.
  always_comb begin
    tx_state_n = tx_state;
    tx_tmr_n   = tx_tmr + 16'd1;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_load_c  = 1'b0;
    tx_line_n  = 1'b1;
    case (tx_state)
      S_IDLE: begin
        tx_tmr_n  = '0;
        tx_load_c = tx_avail;
      end
      S_START: begin
        if (tx_tmr == tx_div) begin
          tx_state_n = S_DATA;
          tx_tmr_n   = '0;
          tx_bit_n   = '0;
        end
      end
      S_DATA: begin
        if (tx_tmr == tx_div) begin
          tx_tmr_n = '0;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          tx_bit_n = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (tx_tmr == tx_div) begin
          tx_tmr_n   = '0;
          tx_state_n = S_IDLE;
          tx_load_c  = tx_avail;
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
    if (tx_load_c) begin
      tx_state_n = S_START;
      tx_sh_n    = tx_head;
      tx_div_n   = div;
      tx_tmr_n   = '0;
    end
    case (tx_state_n)
      S_START: tx_line_n = 1'b0;
      S_DATA:  tx_line_n = tx_sh_n[0];
      default: tx_line_n = 1'b1;
    endcase
  end

  // RX synchroniser plus one extra flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= S_IDLE;
      rx_tmr   <= '0;
      rx_div   <= DIV_RESET;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_s1    <= rx_in;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_n;
      rx_tmr   <= rx_tmr_n;
      rx_div   <= rx_div_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
    end
  end

  assign rx_half = (17'(rx_div) + 17'd1) >> 1;

  // RX next state: mid-bit sampling, glitch rejection on the start sample.
  always_comb begin
    rx_state_n = rx_state;
    rx_tmr_n   = rx_tmr + 16'd1;
    rx_div_n   = rx_div;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_push_c  = 1'b0;
    rx_fe_c    = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_tmr_n = '0;
        if (rx_s3 && !rx_s2) begin
          rx_state_n = S_START;
          rx_div_n   = div;
        end
      end
      S_START: begin
        if ((17'(rx_tmr) + 17'd1) >= rx_half) begin
          rx_tmr_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_tmr == rx_div) begin
          rx_tmr_n = '0;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          rx_bit_n = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_tmr == rx_div) begin
          rx_tmr_n   = '0;
          rx_push_c  = 1'b1;
          rx_fe_c    = !rx_s2;
          rx_state_n = S_IDLE;
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end
endmodule
